// File: rtl/product_accum_if.sv
// Handshake bundle between the multiplier side and product_accum.
//   start/len      : burst request from the controller
//   in_valid/ready : product stream (product[7:0])
//   out_valid/ready: result handshake (acc_out, overflow)
//   busy           : accumulator engaged (ACCUM or DONE)
// master drives requests/products and consumes results; slave is the accumulator.
interface product_accum_if #(
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned COUNT_W = 4
);
    logic               start;
    logic [COUNT_W-1:0] len;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         product;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   acc_out;
    logic               overflow;
    logic               busy;

    modport master (
        output start, len, in_valid, product, out_ready,
        input  in_ready, out_valid, acc_out, overflow, busy
    );

    modport slave (
        input  start, len, in_valid, product, out_ready,
        output in_ready, out_valid, acc_out, overflow, busy
    );
endinterface

// File: rtl/product_accum.sv
// product_accum: sums a programmed burst of 8-bit unsigned products.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : product_accum_if.slave (start/len, product stream, result, busy)
// Overflow is sticky for the burst. Optional macro PRODUCT_ACCUM_SAT_EN
// clamps acc_out at 2**ACC_W-1 on overflow; without it the sum wraps.
// All outputs come straight from registers.
module product_accum #(
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned COUNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    product_accum_if.slave bus
);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [COUNT_W-1:0] cnt;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic               accept;
    logic               result_valid;
    logic               active;
    logic [SUM_W-1:0]   sum_c;

    // One extra bit captures the carry out of the accumulator.
    assign sum_c = SUM_W'(acc) + SUM_W'(bus.product);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            ovf          <= 1'b0;
            accept       <= 1'b0;
            result_valid <= 1'b0;
            active       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        ovf    <= 1'b0;
                        cnt    <= bus.len;
                        active <= 1'b1;
                        if (bus.len != '0) begin
                            state  <= ACCUM;
                            accept <= 1'b1;
                        end else begin
                            // Empty burst goes straight to a zero result.
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        cnt <= cnt - COUNT_W'(1);
`ifdef PRODUCT_ACCUM_SAT_EN
                        // Once clamped, stay clamped for the rest of the burst.
                        if (sum_c[ACC_W] || ovf) begin
                            acc <= '1;
                        end else begin
                            acc <= sum_c[ACC_W-1:0];
                        end
`else
                        acc <= sum_c[ACC_W-1:0];
`endif
                        if (sum_c[ACC_W]) begin
                            ovf <= 1'b1;
                        end
                        if (cnt == COUNT_W'(1)) begin
                            state        <= DONE;
                            accept       <= 1'b0;
                            result_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A start seen here is dropped; only the exit happens.
                    if (bus.out_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        active       <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    accept       <= 1'b0;
                    result_valid <= 1'b0;
                    active       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = accept;
    assign bus.out_valid = result_valid;
    assign bus.acc_out   = acc;
    assign bus.overflow  = ovf;
    assign bus.busy      = active;
endmodule

// File: tb/tb_product_accum.sv
// Directed self-checking bench for product_accum (default 12-bit and a 10-bit instance).
module tb_product_accum;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    product_accum_if #(.ACC_W(12), .COUNT_W(4)) m();
    product_accum_if #(.ACC_W(10), .COUNT_W(4)) s();

    product_accum #(.ACC_W(12), .COUNT_W(4)) dut (.clk(clk), .rst(rst), .bus(m.slave));
    product_accum #(.ACC_W(10), .COUNT_W(4)) dut10 (.clk(clk), .rst(rst), .bus(s.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m.start = 0; m.len = 0; m.in_valid = 0; m.product = 0; m.out_ready = 0;
        s.start = 0; s.len = 0; s.in_valid = 0; s.product = 0; s.out_ready = 0;
        tick(); tick();
        tests++; if (m.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", m.in_ready); end
        tests++; if (m.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", m.out_valid); end
        tests++; if (m.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", m.busy); end
        tests++; if (m.acc_out !== 12'd0) begin fails++; $display("FAIL rst_acc got %0d want 0", m.acc_out); end
        tests++; if (m.overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf got %b want 0", m.overflow); end
        tests++; if (s.acc_out !== 10'd0 || s.overflow !== 1'b0) begin fails++; $display("FAIL rst_dut10 got acc=%0d ovf=%b want 0/0", s.acc_out, s.overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        m.start = 1; m.len = 4'd3;
        tick();
        m.start = 0;
        tests++; if (m.in_ready !== 1'b1 || m.busy !== 1'b1) begin fails++; $display("FAIL b2b_accum got in_ready=%b busy=%b want 1/1", m.in_ready, m.busy); end
        m.in_valid = 1; m.product = 8'd225; tick();
        m.product = 8'd100; tick();
        m.product = 8'd1;
        tests++; if (m.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_early_valid got %b want 0", m.out_valid); end
        tick();
        m.in_valid = 0;
        tests++; if (m.out_valid !== 1'b1 || m.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_done got out_valid=%b in_ready=%b want 1/0", m.out_valid, m.in_ready); end
        tests++; if (m.acc_out !== 12'd326 || m.overflow !== 1'b0) begin fails++; $display("FAIL b2b_sum got %0d ovf=%b want 326/0", m.acc_out, m.overflow); end
        m.out_ready = 1; tick();
        m.out_ready = 0;
        tests++; if (m.out_valid !== 1'b0 || m.busy !== 1'b0 || m.acc_out !== 12'd326) begin fails++; $display("FAIL b2b_idle got out_valid=%b busy=%b acc=%0d want 0/0/326", m.out_valid, m.busy, m.acc_out); end
    endtask

    task automatic test_gaps_and_stall();
        logic [7:0] prods [3];
        prods[0] = 8'd225; prods[1] = 8'd100; prods[2] = 8'd1;
        m.start = 1; m.len = 4'd3; tick();
        m.start = 0;
        for (int i = 0; i < 3; i++) begin
            m.in_valid = 0; tick(); tick();
            tests++; if (m.in_ready !== 1'b1 || m.out_valid !== 1'b0) begin fails++; $display("FAIL gap_hold_%0d got in_ready=%b out_valid=%b want 1/0", i, m.in_ready, m.out_valid); end
            m.in_valid = 1; m.product = prods[i]; tick();
        end
        m.in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tests++; if (m.out_valid !== 1'b1 || m.acc_out !== 12'd326) begin fails++; $display("FAIL stall_%0d got out_valid=%b acc=%0d want 1/326", i, m.out_valid, m.acc_out); end
            m.start = 1; m.len = 4'd2; tick();
        end
        // start and out_ready together: only the exit happens
        m.out_ready = 1; tick();
        m.out_ready = 0; m.start = 0;
        tests++; if (m.busy !== 1'b0 || m.out_valid !== 1'b0) begin fails++; $display("FAIL stall_exit got busy=%b out_valid=%b want 0/0", m.busy, m.out_valid); end
        tick();
        tests++; if (m.busy !== 1'b0 || m.in_ready !== 1'b0 || m.acc_out !== 12'd326) begin fails++; $display("FAIL start_not_queued got busy=%b in_ready=%b acc=%0d want 0/0/326", m.busy, m.in_ready, m.acc_out); end
    endtask

    task automatic test_empty_burst();
        m.start = 1; m.len = 4'd0; tick();
        m.start = 0;
        tests++; if (m.out_valid !== 1'b1 || m.in_ready !== 1'b0) begin fails++; $display("FAIL empty_done got out_valid=%b in_ready=%b want 1/0", m.out_valid, m.in_ready); end
        tests++; if (m.acc_out !== 12'd0 || m.overflow !== 1'b0) begin fails++; $display("FAIL empty_sum got %0d ovf=%b want 0/0", m.acc_out, m.overflow); end
        m.out_ready = 1; tick();
        m.out_ready = 0;
        tests++; if (m.in_ready !== 1'b0 || m.out_valid !== 1'b0 || m.busy !== 1'b0) begin fails++; $display("FAIL empty_idle got in_ready=%b out_valid=%b busy=%b want 0/0/0", m.in_ready, m.out_valid, m.busy); end
    endtask

    task automatic test_overflow();
        logic [9:0] want;
`ifdef PRODUCT_ACCUM_SAT_EN
        want = 10'd1023;
`else
        want = 10'd101;
`endif
        s.start = 1; s.len = 4'd5; tick();
        s.start = 0;
        s.in_valid = 1; s.product = 8'd225;
        for (int i = 0; i < 4; i++) tick();
        tests++; if (s.overflow !== 1'b0 || s.acc_out !== 10'd900) begin fails++; $display("FAIL ovf_pre got acc=%0d ovf=%b want 900/0", s.acc_out, s.overflow); end
        tick();
        s.in_valid = 0;
        tests++; if (s.out_valid !== 1'b1 || s.acc_out !== want || s.overflow !== 1'b1) begin fails++; $display("FAIL ovf_result got valid=%b acc=%0d ovf=%b want 1/%0d/1", s.out_valid, s.acc_out, s.overflow, want); end
        s.out_ready = 1; tick();
        s.out_ready = 0;
        tests++; if (s.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky_idle got %b want 1", s.overflow); end
        s.start = 1; s.len = 4'd1; tick();
        s.start = 0;
        tests++; if (s.overflow !== 1'b0 || s.acc_out !== 10'd0) begin fails++; $display("FAIL ovf_clear got acc=%0d ovf=%b want 0/0", s.acc_out, s.overflow); end
        s.in_valid = 1; s.product = 8'd5; tick();
        s.in_valid = 0;
        tests++; if (s.acc_out !== 10'd5 || s.overflow !== 1'b0) begin fails++; $display("FAIL ovf_next_burst got acc=%0d ovf=%b want 5/0", s.acc_out, s.overflow); end
        s.out_ready = 1; tick();
        s.out_ready = 0;
    endtask

    task automatic test_mid_burst_reset();
        m.start = 1; m.len = 4'd4; tick();
        m.start = 0;
        m.in_valid = 1; m.product = 8'd50; tick(); tick();
        tests++; if (m.acc_out !== 12'd100 || m.in_ready !== 1'b1) begin fails++; $display("FAIL mid_partial got acc=%0d in_ready=%b want 100/1", m.acc_out, m.in_ready); end
        rst = 1; tick();
        rst = 0; m.in_valid = 0;
        tests++; if (m.acc_out !== 12'd0 || m.in_ready !== 1'b0 || m.busy !== 1'b0 || m.out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset got acc=%0d in_ready=%b busy=%b out_valid=%b want 0/0/0/0", m.acc_out, m.in_ready, m.busy, m.out_valid); end
        m.start = 1; m.len = 4'd1; tick();
        m.start = 0;
        m.in_valid = 1; m.product = 8'd7; tick();
        m.in_valid = 0;
        tests++; if (m.acc_out !== 12'd7 || m.out_valid !== 1'b1 || m.overflow !== 1'b0) begin fails++; $display("FAIL post_reset_burst got acc=%0d valid=%b ovf=%b want 7/1/0", m.acc_out, m.out_valid, m.overflow); end
        m.out_ready = 1; tick();
        m.out_ready = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        test_reset();
        test_back_to_back();
        test_gaps_and_stall();
        test_empty_burst();
        test_overflow();
        test_mid_burst_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
